fetch: RTL and testbench

Instruction fetch unit: owns the program counter, issues word reads to instruction memory, buffers returned words, and presents one instruction per handshake on `ins` to the control decoder. It is the producer side of the `ins` bus that the decoder consumes. It accepts PC redirects from the branch/jump path and discards stale in-flight responses after a redirect.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/ins_fifo.sv | 65 ++++++
 rtl/fetch.sv | 140 ++++++++++++++
 tb/tb_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int unsigned INS_W            = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INS_W-1:0] NOP_WORD    = '0;

  // Fetch addresses are word addresses; the low two bits never reach memory.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ins_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, instruction} pairs.
// An empty FIFO presents all-zero head data so the consumer sees a NOP at pc 0.
module ins_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [31:0]      push_pc,
  input  logic [INS_W-1:0] push_ins,
  input  logic             pop,
  output logic [31:0]      head_pc,
  output logic [INS_W-1:0] head_ins,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [32+INS_W-1:0] mem [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  assign head_pc  = empty ? 32'h0000_0000 : mem[rd_ptr][32+INS_W-1:INS_W];
  assign head_ins = empty ? NOP_WORD      : mem[rd_ptr][INS_W-1:0];

  // Pointer and occupancy tracking; clear wins over any push/pop that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_pc, push_ins};
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: owns the PC, issues word reads, buffers returned
// words and hands them to the decoder one per handshake. After a redirect,
// responses still in flight belong to the old stream and are counted off
// via `drop` before fetching resumes.
//
// state | meaning
// BOOT  | first cycle out of reset, no requests (redirect only loads PCs)
// RUN   | issuing requests while credit allows, enqueueing responses
// FLUSH | waiting for stale responses to drain after a redirect
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [INS_W-1:0] ins,
  output logic [31:0]      ins_pc,
  output logic             ins_valid,
  input  logic             ins_ready
);

  localparam int unsigned CW         = $clog2(DEPTH) + 1;
  localparam logic [31:0] BOOT_PC    = word_align(RESET_PC);
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic          issue;
  logic          resp;
  logic          keep;
  logic          flush;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;

  // Requests in flight plus words already buffered may never exceed the
  // buffer size, so every response always has a slot waiting for it.
  assign credit    = {1'b0, outstanding} + {1'b0, count};
  assign imem_req  = (state == RUN) && (credit < CREDIT_MAX);
  assign imem_addr = pc;

  assign issue     = imem_req && imem_ready;
  assign resp      = imem_rvalid && (outstanding != '0);
  assign flush     = redirect && (state != BOOT);
  assign keep      = resp && (drop == '0) && !redirect;
  assign pop       = ins_valid && ins_ready && !flush;
  assign target_pc = word_align(redirect_pc);
  assign ins_valid = !fifo_empty;

  assign outstanding_nxt = outstanding + CW'(issue) - CW'(resp);

  // On a flush everything still in flight after this edge is stale,
  // including an issue accepted in the redirect cycle itself.
  always_comb begin
    drop_nxt = drop;
    if (flush) begin
      drop_nxt = outstanding_nxt;
    end else if (resp && (drop != '0)) begin
      drop_nxt = drop - CW'(1);
    end
  end

  // Next-state logic; FLUSH is left in the same cycle the last stale word lands.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (flush && (drop_nxt != '0)) state_nxt = FLUSH;
      FLUSH:   if (drop_nxt == '0) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= BOOT_PC;
      resp_pc     <= BOOT_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      if (redirect) begin
        pc      <= target_pc;
        resp_pc <= target_pc;
      end else begin
        if (issue) pc      <= pc + 32'd4;
        if (keep)  resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  ins_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ins_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (keep),
    .push_pc  (resp_pc),
    .push_ins (imem_rdata),
    .pop      (pop),
    .head_pc  (ins_pc),
    .head_ins (ins),
    .count    (count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Memory must never answer a request that was not issued.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding == '0)));

  // The credit rule keeps a kept response from landing in a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(keep && fifo_full && !pop));

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch unit: an in-order memory with random latency and a
// stream model (after reset or redirect the fetched and delivered addresses
// run target, target+4, ...; words issued before a redirect never appear).
module tb_fetch;
  import fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;
  logic        ins_ready;

  fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  // Memory contents: a bijective scramble of the address.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: in-order pending responses tagged with the stream epoch.
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          q_ep[$];
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  logic [31:0] exp_issue;
  logic [31:0] exp_pc;
  int          n_issue = 0;
  int          n_cons = 0;
  int          rdy_pct = 100;
  int          irdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_addr;
  bit          first_armed = 0;
  logic [31:0] first_pc;
  logic [31:0] prev_issue_addr = 32'h1;
  bit          wrap_seen = 0;

  task automatic step(input bit rd, input logic [31:0] tgt);
    int  stale;
    bit  iss;
    @(negedge clk);
    imem_ready  = ($urandom_range(0, 99) < rdy_pct);
    ins_ready   = ($urandom_range(0, 99) < irdy_pct);
    redirect    = rd;
    redirect_pc = tgt;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(q_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req = imem_req; s_valid = ins_valid; s_pc = ins_pc; s_addr = imem_addr;
    if (!ins_valid) begin
      chk("empty_ins", ins, 0);
      chk("empty_ins_pc", ins_pc, 0);
    end
    if (imem_req) begin
      stale = 0;
      foreach (q_ep[i]) if (q_ep[i] != epoch) stale++;
      chk("req_addr", imem_addr, exp_issue);
      chk("req_while_stale", stale, 0);
    end
    if (ins_valid && ins_ready && !redirect) begin
      chk("ins_pc", ins_pc, exp_pc);
      chk("ins_word", ins, data_of(exp_pc));
      if (first_armed) begin first_pc = ins_pc; first_armed = 0; end
      exp_pc += 32'd4;
      n_cons++;
    end
    iss = imem_req && imem_ready;
    if (imem_rvalid) begin
      void'(q_addr.pop_front()); void'(q_due.pop_front()); void'(q_ep.pop_front());
    end
    if (iss) begin
      int due;
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      q_addr.push_back(imem_addr); q_due.push_back(due); q_ep.push_back(epoch);
      last_due = due;
      if (prev_issue_addr == 32'hFFFF_FFFC && imem_addr == 32'h0) wrap_seen = 1;
      prev_issue_addr = imem_addr;
      exp_issue += 32'd4;
      n_issue++;
    end
    if (rd) begin
      epoch++;
      exp_issue = {tgt[31:2], 2'b00};
      exp_pc    = {tgt[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic apply_reset();
    @(negedge clk);
    imem_rvalid = 1'b0; redirect = 1'b0; imem_ready = 1'b1; ins_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_ins", ins, 0);
    chk("rst_ins_pc", ins_pc, 0);
    chk("rst_valid", ins_valid, 0);
    q_addr.delete(); q_due.delete(); q_ep.delete();
    epoch++;
    exp_issue = RST_PC; exp_pc = RST_PC;
    first_armed = 0; prev_issue_addr = 32'h1;
    @(posedge clk); cyc++;
    last_due = cyc;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("boot_no_req", imem_req, 0);
    @(posedge clk); cyc++;
  endtask

  // Redirect, then check when fetching resumes and what is delivered first.
  task automatic redirect_gap(input logic [31:0] tgt, input string tag);
    int exp_req;
    int got;
    exp_req = cyc + 1;
    irdy_pct = 100;
    first_pc = 32'hDEAD_BEEF;
    first_armed = 1;
    step(1'b1, tgt);
    foreach (q_ep[i]) if (q_ep[i] != epoch && q_due[i] + 1 > exp_req) exp_req = q_due[i] + 1;
    got = -1;
    for (int k = 0; k < 30 && got < 0; k++) begin
      step(1'b0, 32'h0);
      if (s_req) got = cyc - 1;
    end
    chk({tag, "_resume_cycle"}, got, exp_req);
    repeat (12) step(1'b0, 32'h0);
    chk({tag, "_first_pc"}, first_pc, {tgt[31:2], 2'b00});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] tgt;
    rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;

    // Streaming from reset with 1-cycle memory.
    rdy_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1;
    apply_reset();
    step(1'b0, 32'h0); chk("c1_req", s_req, 1); chk("c1_addr", s_addr, RST_PC);
    step(1'b0, 32'h0); chk("c2_valid", s_valid, 0);
    step(1'b0, 32'h0); chk("c3_valid", s_valid, 1); chk("c3_ins_pc", s_pc, RST_PC);
    base = n_cons;
    repeat (20) step(1'b0, 32'h0);
    chk("stream_progress", (n_cons - base) >= 8, 1);

    // Decoder stalled: credit limits issue to DEPTH requests.
    irdy_pct = 0;
    apply_reset();
    base = n_issue;
    repeat (20) step(1'b0, 32'h0);
    chk("stall_issue_count", n_issue - base, DEPTH);
    chk("stall_req_low", s_req, 0);
    irdy_pct = 100;
    base = n_cons;
    repeat (20) step(1'b0, 32'h0);
    chk("resume_progress", (n_cons - base) >= 8, 1);

    // Redirect with two requests in flight, 3-cycle memory.
    irdy_pct = 0; lat_min = 3; lat_max = 3;
    apply_reset();
    step(1'b0, 32'h0); step(1'b0, 32'h0);
    redirect_gap(32'h0000_0100, "flush2");

    // Redirect coinciding with a response and an accepted issue.
    irdy_pct = 0; lat_min = 1; lat_max = 1;
    apply_reset();
    step(1'b0, 32'h0);
    redirect_gap(32'h0000_0402, "same_cycle");

    // Back-to-back redirects while flushing.
    irdy_pct = 0; lat_min = 3; lat_max = 3;
    apply_reset();
    step(1'b0, 32'h0); step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0200);
    redirect_gap(32'h0000_0300, "b2b");

    // PC wrap-around.
    lat_min = 1; lat_max = 1; wrap_seen = 0;
    redirect_gap(32'hFFFF_FFFC, "wrap");
    chk("wrap_seen", wrap_seen, 1);

    // Reset in the middle of a full buffer.
    irdy_pct = 0;
    repeat (6) step(1'b0, 32'h0);
    chk("pre_rst_valid", s_valid, 1);
    apply_reset();
    irdy_pct = 100;
    step(1'b0, 32'h0); chk("post_rst_addr", s_addr, RST_PC); chk("post_rst_req", s_req, 1);
    repeat (10) step(1'b0, 32'h0);

    // Randomized traffic.
    base = n_cons;
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 2))
        0: rdy_pct = 100;
        1: rdy_pct = 70;
        default: rdy_pct = 30;
      endcase
      case ($urandom_range(0, 2))
        0: irdy_pct = 100;
        1: irdy_pct = 70;
        default: irdy_pct = 30;
      endcase
      lat_min = 1; lat_max = $urandom_range(1, 4);
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 99) < 4) begin
          if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
          else tgt = $urandom;
          step(1'b1, tgt);
        end else begin
          step(1'b0, 32'h0);
        end
      end
      if (seg == 10) apply_reset();
    end
    chk("random_progress", (n_cons - base) > 200, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
